// File: rtl/rmon_pkg.sv
// Shared types and default widths for the RMON statistics accumulation block.
package rmon_pkg;

  localparam int RMON_ADDR_W  = 6;
  localparam int RMON_DATA_W  = 32;
  localparam int RMON_INC_W   = 16;
  localparam int RMON_PORT_TX = 0;
  localparam int RMON_PORT_RX = 1;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD,
    ST_WR
  } rmon_state_e;

endpackage

// File: rtl/rmon_accum_ctrl_if.sv
// Request strobes from the TX/RX statistics sources plus RAM port A of the RMON counters.
import rmon_pkg::*;

interface rmon_accum_ctrl_if #(
  parameter int ADDR_W = RMON_ADDR_W,
  parameter int DATA_W = RMON_DATA_W,
  parameter int INC_W  = RMON_INC_W
);
  // Index 0 is the TX source, index 1 the RX source.
  logic [1:0]             req_apply;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][INC_W-1:0]  req_data;
  logic [1:0]             req_next;
  logic [1:0]             req_ovf;
  logic [ADDR_W-1:0]      addra;
  logic [DATA_W-1:0]      dina;
  logic                   wea;
  logic [DATA_W-1:0]      douta;
  logic                   init_done;

  modport master (
    output req_apply, req_addr, req_data, douta,
    input  req_next, req_ovf, addra, dina, wea, init_done
  );

  modport slave (
    input  req_apply, req_addr, req_data, douta,
    output req_next, req_ovf, addra, dina, wea, init_done
  );
endinterface

// File: rtl/rmon_req_latch.sv
// One-entry request holding register for a statistics source, with a dropped-strobe pulse.
module rmon_req_latch #(
  parameter int ADDR_W = 6,
  parameter int INC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              apply,
  input  logic [ADDR_W-1:0] addr,
  input  logic [INC_W-1:0]  data,
  input  logic              grant,
  output logic              valid,
  output logic [ADDR_W-1:0] lat_addr,
  output logic [INC_W-1:0]  lat_data,
  output logic              ovf
);
  logic              valid_reg;
  logic              ovf_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [INC_W-1:0]  data_reg;
  logic              load;

  // A grant in the same cycle frees the entry, so the new strobe takes it.
  assign load = apply && (!valid_reg || grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      ovf_reg <= apply && valid_reg && !grant;
      if (load) begin
        valid_reg <= 1'b1;
        addr_reg  <= addr;
        data_reg  <= data;
      end else if (grant) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign valid    = valid_reg;
  assign lat_addr = addr_reg;
  assign lat_data = data_reg;
  assign ovf      = ovf_reg;
endmodule

// File: rtl/rmon_accum_ctrl.sv
// RMON counter read-modify-write engine: clears the RAM after reset, then round-robins TX/RX increments.
// Define RMON_SATURATE_EN to clamp counters at all-ones instead of wrapping.
module rmon_accum_ctrl
  import rmon_pkg::*;
#(
  parameter int ADDR_W = RMON_ADDR_W,
  parameter int DATA_W = RMON_DATA_W,
  parameter int INC_W  = RMON_INC_W
) (
  input logic             clk,
  input logic             reset,
  rmon_accum_ctrl_if.slave bus
);
  logic [1:0]             lat_valid;
  logic [1:0][ADDR_W-1:0] lat_addr;
  logic [1:0][INC_W-1:0]  lat_data;
  logic [1:0]             lat_ovf;
  logic [1:0]             grant;
  logic                   pick;

  rmon_state_e       state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [INC_W-1:0]  inc_reg;
  logic              last_reg;
  logic              init_done_reg;
  logic [DATA_W-1:0] upd;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      rmon_req_latch #(
        .ADDR_W(ADDR_W),
        .INC_W (INC_W)
      ) u_latch (
        .clk     (clk),
        .reset   (reset),
        .apply   (bus.req_apply[gi]),
        .addr    (bus.req_addr[gi]),
        .data    (bus.req_data[gi]),
        .grant   (grant[gi]),
        .valid   (lat_valid[gi]),
        .lat_addr(lat_addr[gi]),
        .lat_data(lat_data[gi]),
        .ovf     (lat_ovf[gi])
      );
    end
  endgenerate

  // On a tie take the port not served last; a lone request wins outright.
  always_comb begin
    pick  = (lat_valid == 2'b11) ? ~last_reg : lat_valid[RMON_PORT_RX];
    grant = 2'b00;
    if (state_reg == ST_IDLE)
      grant = (pick ? 2'b10 : 2'b01) & lat_valid;
  end

`ifdef RMON_SATURATE_EN
  logic [DATA_W:0] sum;
  always_comb begin
    sum = {1'b0, bus.douta} + (DATA_W+1)'(inc_reg);
    upd = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
  end
`else
  always_comb begin
    upd = bus.douta + DATA_W'(inc_reg);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_INIT;
      addr_reg      <= '0;
      inc_reg       <= '0;
      last_reg      <= 1'b1;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          addr_reg <= addr_reg + ADDR_W'(1);
          if (addr_reg == '1) begin
            state_reg     <= ST_IDLE;
            init_done_reg <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (|lat_valid) begin
            last_reg  <= pick;
            addr_reg  <= lat_addr[pick];
            inc_reg   <= lat_data[pick];
            state_reg <= ST_RD;
          end
        end
        ST_RD:   state_reg <= ST_WR;
        ST_WR:   state_reg <= ST_IDLE;
        default: state_reg <= ST_INIT;
      endcase
    end
  end

  // Write enable is gated by reset so an abandoned WR never lands in the RAM.
  assign bus.wea       = !reset && (state_reg == ST_INIT || state_reg == ST_WR);
  assign bus.addra     = addr_reg;
  assign bus.dina      = (state_reg == ST_WR) ? upd : '0;
  assign bus.req_next  = grant;
  assign bus.req_ovf   = lat_ovf;
  assign bus.init_done = init_done_reg;
endmodule

// File: tb/tb_rmon_accum_ctrl.sv
// Self-checking bench for rmon_accum_ctrl: the bench owns the RAM and a counter-level reference model.
module tb_rmon_accum_ctrl;
  import rmon_pkg::*;

  localparam int AW    = RMON_ADDR_W;
  localparam int DW    = RMON_DATA_W;
  localparam int IW    = RMON_INC_W;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b1;

  rmon_accum_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .INC_W(IW)) bus ();

  rmon_accum_ctrl #(.ADDR_W(AW), .DATA_W(DW), .INC_W(IW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_waddr = '0;
  logic [DW-1:0] tb_wdata = '0;
  int checks = 0;
  int failures = 0;

  // Port A RAM with registered read; the bench port lets tests preload words.
  always @(posedge clk) begin
    if (tb_we) mem[tb_waddr] <= tb_wdata;
    else if (bus.wea) mem[bus.addra] <= bus.dina;
    bus.douta <= mem[bus.addra];
  end

  function automatic logic [DW-1:0] model_add(input logic [DW-1:0] cur, input logic [IW-1:0] inc);
    longint unsigned s;
    s = 64'(cur) + 64'(inc);
`ifdef RMON_SATURATE_EN
    if (s > ((64'd1 << DW) - 64'd1)) s = (64'd1 << DW) - 64'd1;
`endif
    return s[DW-1:0];
  endfunction

  task automatic drive(input logic [1:0] ap, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [IW-1:0] d0, input logic [IW-1:0] d1);
    bus.req_apply   = ap;
    bus.req_addr[0] = a0;
    bus.req_addr[1] = a1;
    bus.req_data[0] = d0;
    bus.req_data[1] = d1;
  endtask

  task automatic test_reset();
    drive(2'b00, '0, '0, '0, '0);
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      tb_we = 1'b1; tb_waddr = AW'(i); tb_wdata = DW'($urandom) | DW'(1);
    end
    @(negedge clk);
    tb_we = 1'b0;
    checks++;
    if (bus.wea !== 1'b0 || bus.addra !== '0 || bus.dina !== '0) begin
      failures++;
      $display("FAIL reset_ram: wea=%b addra=%0d dina=%h want 0/0/0", bus.wea, bus.addra, bus.dina);
    end
    checks++;
    if (bus.req_next !== 2'b00 || bus.req_ovf !== 2'b00 || bus.init_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: next=%b ovf=%b init_done=%b want 00/00/0", bus.req_next, bus.req_ovf, bus.init_done);
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if (bus.wea !== 1'b1 || bus.addra !== AW'(i) || bus.dina !== '0 || bus.init_done !== 1'b0) begin
        failures++;
        $display("FAIL clear_step: wea=%b addra=%0d dina=%h init_done=%b want 1/%0d/0/0", bus.wea, bus.addra, bus.dina, bus.init_done, i);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (bus.init_done !== 1'b1 || bus.wea !== 1'b0) begin
      failures++;
      $display("FAIL init_done: init_done=%b wea=%b want 1/0", bus.init_done, bus.wea);
    end
    for (int a = 0; a < DEPTH; a++) begin
      exp_mem[a] = '0;
      checks++;
      if (mem[a] !== '0) begin
        failures++;
        $display("FAIL clear_ram: mem[%0d]=%h want 0", a, mem[a]);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_tie();
    logic [IW-1:0] da, db, dc, dd, inc;
    logic [1:0] exp_next;
    logic exp_wea;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] expv;
    da = IW'($urandom); db = IW'($urandom); dc = IW'($urandom); dd = IW'($urandom);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      exp_next = (c == 1 || c == 7) ? 2'b01 : (c == 4 || c == 10) ? 2'b10 : 2'b00;
      exp_wea  = (c == 3 || c == 6 || c == 9 || c == 12);
      exp_addr = (c == 3 || c == 9) ? AW'(1) : AW'(2);
      inc      = (c == 3) ? da : (c == 6) ? db : (c == 9) ? dc : dd;
      checks++;
      if (bus.req_next !== exp_next || bus.wea !== exp_wea || bus.req_ovf !== 2'b00) begin
        failures++;
        $display("FAIL tie_cycle%0d: next=%b wea=%b ovf=%b want %b/%b/00", c, bus.req_next, bus.wea, bus.req_ovf, exp_next, exp_wea);
      end
      if (exp_wea) begin
        expv = model_add(exp_mem[exp_addr], inc);
        checks++;
        if (bus.addra !== exp_addr || bus.dina !== expv) begin
          failures++;
          $display("FAIL tie_wr%0d: addra=%0d dina=%h want %0d/%h", c, bus.addra, bus.dina, exp_addr, expv);
        end
        exp_mem[exp_addr] = expv;
      end
      case (c)
        0:       drive(2'b11, AW'(1), AW'(2), da, db);
        1:       drive(2'b01, AW'(1), AW'(2), dc, dd);
        4:       drive(2'b10, AW'(1), AW'(2), dc, dd);
        default: drive(2'b00, AW'(1), AW'(2), dc, dd);
      endcase
    end
    for (int a = 1; a <= 2; a++) begin
      checks++;
      if (mem[a] !== exp_mem[a]) begin
        failures++;
        $display("FAIL tie_ram: mem[%0d]=%h want %h", a, mem[a], exp_mem[a]);
      end
    end
    $display("test_tie done");
  endtask

  task automatic test_repeat();
    logic [DW-1:0] expv;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(2'b01, AW'(5), '0, IW'(3), '0);
      @(negedge clk); drive(2'b00, AW'(5), '0, IW'(3), '0);
      checks++;
      if (bus.req_next !== 2'b01) begin
        failures++;
        $display("FAIL rep_next%0d: next=%b want 01", k, bus.req_next);
      end
      @(negedge clk);
      checks++;
      if (bus.wea !== 1'b0 || bus.addra !== AW'(5) || bus.req_next !== 2'b00) begin
        failures++;
        $display("FAIL rep_rd%0d: wea=%b addra=%0d next=%b want 0/5/00", k, bus.wea, bus.addra, bus.req_next);
      end
      @(negedge clk);
      expv = model_add(exp_mem[5], IW'(3));
      checks++;
      if (bus.wea !== 1'b1 || bus.addra !== AW'(5) || bus.dina !== expv) begin
        failures++;
        $display("FAIL rep_wr%0d: wea=%b addra=%0d dina=%h want 1/5/%h", k, bus.wea, bus.addra, bus.dina, expv);
      end
      exp_mem[5] = expv;
      @(negedge clk);
      checks++;
      if (bus.wea !== 1'b0) begin
        failures++;
        $display("FAIL rep_wea_once%0d: wea=%b want 0", k, bus.wea);
      end
    end
    checks++;
    if (mem[5] !== DW'(9)) begin
      failures++;
      $display("FAIL rep_ram: mem[5]=%h want 9", mem[5]);
    end
    $display("test_repeat done");
  endtask

  task automatic test_ovf();
    logic [IW-1:0] dr, d1, d2;
    logic [1:0] exp_next, exp_ovf;
    logic exp_wea;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] expv;
    dr = IW'($urandom); d1 = IW'($urandom); d2 = IW'($urandom);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      exp_next = (c == 1) ? 2'b10 : (c == 4) ? 2'b01 : 2'b00;
      exp_ovf  = (c == 3) ? 2'b01 : 2'b00;
      exp_wea  = (c == 3 || c == 6);
      exp_addr = (c == 3) ? AW'(10) : AW'(9);
      checks++;
      if (bus.req_next !== exp_next || bus.req_ovf !== exp_ovf || bus.wea !== exp_wea) begin
        failures++;
        $display("FAIL ovf_cycle%0d: next=%b ovf=%b wea=%b want %b/%b/%b", c, bus.req_next, bus.req_ovf, bus.wea, exp_next, exp_ovf, exp_wea);
      end
      if (exp_wea) begin
        expv = model_add(exp_mem[exp_addr], (c == 3) ? dr : d1);
        checks++;
        if (bus.addra !== exp_addr || bus.dina !== expv) begin
          failures++;
          $display("FAIL ovf_wr%0d: addra=%0d dina=%h want %0d/%h", c, bus.addra, bus.dina, exp_addr, expv);
        end
        exp_mem[exp_addr] = expv;
      end
      case (c)
        0:       drive(2'b10, AW'(9), AW'(10), d1, dr);
        1:       drive(2'b01, AW'(9), AW'(10), d1, dr);
        2:       drive(2'b01, AW'(9), AW'(10), d2, dr);
        default: drive(2'b00, AW'(9), AW'(10), d2, dr);
      endcase
    end
    checks++;
    if (mem[9] !== exp_mem[9] || mem[10] !== exp_mem[10]) begin
      failures++;
      $display("FAIL ovf_ram: mem[9]=%h mem[10]=%h want %h/%h", mem[9], mem[10], exp_mem[9], exp_mem[10]);
    end
    $display("test_ovf done");
  endtask

  task automatic test_wrap();
    logic [DW-1:0] expv;
    logic [DW-1:0] want_first;
`ifdef RMON_SATURATE_EN
    want_first = 32'hFFFF_FFFF;
`else
    want_first = 32'h0000_0003;
`endif
    @(negedge clk); tb_we = 1'b1; tb_waddr = AW'(7); tb_wdata = 32'hFFFF_FFFE;
    @(negedge clk); tb_we = 1'b0;
    exp_mem[7] = 32'hFFFF_FFFE;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); drive(2'b01, AW'(7), '0, (k == 0) ? IW'(5) : IW'(1), '0);
      @(negedge clk); drive(2'b00, AW'(7), '0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      expv = model_add(exp_mem[7], (k == 0) ? IW'(5) : IW'(1));
      checks++;
      if (bus.wea !== 1'b1 || bus.dina !== expv) begin
        failures++;
        $display("FAIL wrap_wr%0d: wea=%b dina=%h want 1/%h", k, bus.wea, bus.dina, expv);
      end
      exp_mem[7] = expv;
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (mem[7] !== want_first) begin
          failures++;
          $display("FAIL wrap_first: mem[7]=%h want %h", mem[7], want_first);
        end
      end
    end
    checks++;
    if (mem[7] !== exp_mem[7]) begin
      failures++;
      $display("FAIL wrap_second: mem[7]=%h want %h", mem[7], exp_mem[7]);
    end
    $display("test_wrap done");
  endtask

  task automatic test_random();
    bit busy [2];
    int strobes, weas, ovfs;
    logic [1:0] ap;
    logic [AW-1:0] a [2];
    logic [IW-1:0] d [2];
    busy[0] = 0; busy[1] = 0; strobes = 0; weas = 0; ovfs = 0;
    a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
    for (int c = 0; c < 360; c++) begin
      @(negedge clk);
      if (bus.wea === 1'b1) weas++;
      if (bus.req_ovf !== 2'b00) ovfs++;
      ap = 2'b00;
      for (int p = 0; p < 2; p++) begin
        if (bus.req_next[p] === 1'b1) busy[p] = 0;
        if (c < 300 && !busy[p] && $urandom_range(0, 2) == 0) begin
          ap[p] = 1'b1;
          a[p] = AW'($urandom_range(0, 7));
          d[p] = IW'($urandom);
          exp_mem[a[p]] = model_add(exp_mem[a[p]], d[p]);
          busy[p] = 1;
          strobes++;
        end
      end
      drive(ap, a[0], a[1], d[0], d[1]);
    end
    checks++;
    if (busy[0] || busy[1]) begin
      failures++;
      $display("FAIL rand_drain: busy=%0d%0d want 00 after cycle budget", busy[1], busy[0]);
    end
    checks++;
    if (weas != strobes || ovfs != 0) begin
      failures++;
      $display("FAIL rand_counts: writes=%0d ovf=%0d want %0d/0", weas, ovfs, strobes);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem[k] !== exp_mem[k]) begin
        failures++;
        $display("FAIL rand_ram: mem[%0d]=%h want %h", k, mem[k], exp_mem[k]);
      end
    end
    $display("test_random done strobes=%0d", strobes);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(2'b01, AW'(12), AW'(13), IW'(7), IW'(9));
    @(negedge clk); drive(2'b10, AW'(12), AW'(13), IW'(7), IW'(9));
    checks++;
    if (bus.req_next !== 2'b01) begin
      failures++;
      $display("FAIL rst_grant: next=%b want 01", bus.req_next);
    end
    @(negedge clk); drive(2'b00, '0, '0, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.wea !== 1'b1 || bus.addra !== AW'(12)) begin
      failures++;
      $display("FAIL rst_in_wr: wea=%b addra=%0d want 1/12", bus.wea, bus.addra);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.wea !== 1'b0) begin
      failures++;
      $display("FAIL rst_wr_abort: wea=%b want 0", bus.wea);
    end
    @(negedge clk);
    checks++;
    if (bus.wea !== 1'b0 || bus.addra !== '0 || bus.init_done !== 1'b0 || bus.req_next !== 2'b00) begin
      failures++;
      $display("FAIL rst_state: wea=%b addra=%0d init_done=%b next=%b want 0/0/0/00", bus.wea, bus.addra, bus.init_done, bus.req_next);
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if (bus.wea !== 1'b1 || bus.addra !== AW'(i) || bus.dina !== '0) begin
        failures++;
        $display("FAIL rst_clear: wea=%b addra=%0d dina=%h want 1/%0d/0", bus.wea, bus.addra, bus.dina, i);
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.wea !== 1'b0 || bus.req_next !== 2'b00 || bus.init_done !== 1'b1) begin
        failures++;
        $display("FAIL rst_lost%0d: wea=%b next=%b init_done=%b want 0/00/1", c, bus.wea, bus.req_next, bus.init_done);
      end
    end
    checks++;
    if (mem[12] !== '0 || mem[13] !== '0) begin
      failures++;
      $display("FAIL rst_ram: mem[12]=%h mem[13]=%h want 0/0", mem[12], mem[13]);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_tie();
    test_repeat();
    test_ovf();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
